// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: SRAM-like request/response handshake, pipeline stall,
// store lane replication and load extraction. Define LSU_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        adel,
    output logic        ades,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDiscard} state_e;

    state_e      state_q, state_d;
    logic        req_q;
    logic        wr_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic        fault;
    logic        go;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] rd_shift;

    // Size 11 behaves as a word access everywhere, including on the bus.
    assign req_size = (mem_size == 2'b11) ? 2'b10 : mem_size;

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((req_size == 2'b01) && mem_addr[0])
                    || ((req_size == 2'b10) && (mem_addr[1:0] != 2'b00));
    assign fault    = misalign;
    assign req_addr = mem_addr;
    assign adel     = (state_q == StIdle) && mem_en && misalign && !mem_wr;
    assign ades     = (state_q == StIdle) && mem_en && misalign && mem_wr;
`else
    assign fault = 1'b0;
    assign adel  = 1'b0;
    assign ades  = 1'b0;
    always_comb begin
        req_addr = mem_addr;
        if (req_size == 2'b10) begin
            req_addr[1:0] = 2'b00;
        end else if (req_size == 2'b01) begin
            req_addr[0] = 1'b0;
        end
    end
`endif

    assign go = (state_q == StIdle) && mem_en && !flush && !fault;

    always_comb begin
        st_wdata = mem_wdata;
        st_wstrb = 4'b1111;
        case (req_size)
            2'b00: begin
                st_wdata = {4{mem_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{mem_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!mem_wr) begin
            st_wstrb = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StReq;
            end
            StReq: begin
                if (data_addr_ok) begin
                    state_d = flush ? StDiscard : StWait;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (data_data_ok) begin
                    state_d = StIdle;
                end else if (flush) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (data_data_ok) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            StIdle:    stall = go;
            StReq:     stall = 1'b1;
            StWait: begin
                stall = !data_data_ok;
                done  = data_data_ok && !flush;
            end
            StDiscard: stall = mem_en;
            default:   ;
        endcase
        if (flush) begin
            stall = 1'b0;
        end
    end

    // Bus fields are captured once on issue so they hold steady until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            wstrb_q <= 4'b0;
        end else begin
            req_q <= (state_d == StReq);
            if (go) begin
                wr_q    <= mem_wr;
                sext_q  <= mem_sext;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= st_wdata;
                wstrb_q <= st_wstrb;
            end
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;

    assign rd_shift = data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = 32'b0;
        if (done) begin
            case (size_q)
                2'b00:   ld_data = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
                2'b01:   ld_data = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
                default: ld_data = rd_shift;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level reference model checked every cycle, a scripted
// bus responder, and directed accesses with literal expectations. Honours LSU_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en, mem_wr, mem_sext, flush;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, done, adel, ades;
    logic [31:0] ld_data;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_pass = 0;
    int n_total = 0;

    mem_access_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_sext     (mem_sext),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .ld_data      (ld_data),
        .adel         (adel),
        .ades         (ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        return misal(sz, a);
`else
        return misal(sz, a) && 1'b0;
`endif
    endfunction

    function automatic logic [1:0] norm(input logic [1:0] sz);
        return (sz == 2'b11) ? 2'b10 : sz;
    endfunction

    function automatic logic [31:0] m_busaddr(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        return a;
`else
        if (sz == 2'b10) return a & 32'hFFFF_FFFC;
        if (sz == 2'b01) return a & 32'hFFFF_FFFE;
        return a;
`endif
    endfunction

    function automatic logic [31:0] m_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] b = wd & 32'h0000_00FF;
        logic [31:0] h = wd & 32'h0000_FFFF;
        if (sz == 2'b00) return b * 32'h0101_0101;
        if (sz == 2'b01) return h * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic wr, input logic [31:0] a);
        logic [31:0] off = a % 4;
        if (!wr) return 4'h0;
        if (sz == 2'b10) return 4'hF;
        if (sz == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
        case (off)
            0: return 4'h1;
            1: return 4'h2;
            2: return 4'h4;
            default: return 4'h8;
        endcase
    endfunction

    function automatic logic [31:0] m_extract(input logic [1:0] sz, input logic sx,
                                              input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        logic [31:0] b = v & 32'hFF;
        logic [31:0] h = v & 32'hFFFF;
        if (sz == 2'b00) return (sx && b >= 128) ? b + 32'hFFFF_FF00 : b;
        if (sz == 2'b01) return (sx && h >= 32768) ? h + 32'hFFFF_0000 : h;
        return rd;
    endfunction

    // Outstanding access record: issued, accepted by the bus, cancelled by a flush.
    logic        m_busy, m_acc, m_cancel, m_wr, m_sext;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_cancel <= 1'b0;
        end else if (!m_busy) begin
            if (mem_en && !flush && !m_fault(norm(mem_size), mem_addr)) begin
                m_busy  <= 1'b1; m_acc <= 1'b0; m_cancel <= 1'b0;
                m_wr    <= mem_wr;
                m_sext  <= mem_sext;
                m_size  <= norm(mem_size);
                m_addr  <= m_busaddr(norm(mem_size), mem_addr);
                m_wdata <= m_lanes(norm(mem_size), mem_wdata);
                m_wstrb <= m_strb(norm(mem_size), mem_wr, m_busaddr(norm(mem_size), mem_addr));
            end
        end else if (!m_acc) begin
            if (data_addr_ok) begin
                m_acc <= 1'b1; m_cancel <= flush;
            end else if (flush) begin
                m_busy <= 1'b0;
            end
        end else begin
            if (data_data_ok) m_busy <= 1'b0;
            else if (flush) m_cancel <= 1'b1;
        end
    end

    always @(negedge clk) begin
        logic e_stall, e_done, e_adel, e_ades, flt;
        logic [31:0] e_ld;
        if (!resetn) begin
            chk("rst_stall", 32'(stall), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_req", 32'(data_req), 0);
            chk("rst_wr", 32'(data_wr), 0);
            chk("rst_size", 32'(data_size), 0);
            chk("rst_addr", data_addr, 0);
            chk("rst_wdata", data_wdata, 0);
            chk("rst_wstrb", 32'(data_wstrb), 0);
            chk("rst_ld", ld_data, 0);
        end else begin
            flt = m_fault(norm(mem_size), mem_addr);
            e_done = m_busy && m_acc && !m_cancel && data_data_ok && !flush;
            if (!m_busy) e_stall = mem_en && !flt;
            else if (!m_acc) e_stall = 1'b1;
            else if (!m_cancel) e_stall = !data_data_ok;
            else e_stall = mem_en;
            if (flush) e_stall = 1'b0;
            e_adel = !m_busy && mem_en && flt && !mem_wr;
            e_ades = !m_busy && mem_en && flt && mem_wr;
            e_ld = e_done ? m_extract(m_size, m_sext, m_addr, data_rdata) : 32'h0;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("done", 32'(done), 32'(e_done));
            chk("ld_data", ld_data, e_ld);
            chk("adel", 32'(adel), 32'(e_adel));
            chk("ades", 32'(ades), 32'(e_ades));
            chk("data_req", 32'(data_req), 32'(m_busy && !m_acc));
            if (m_busy && !m_acc) begin
                chk("data_wr", 32'(data_wr), 32'(m_wr));
                chk("data_size", 32'(data_size), 32'(m_size));
                chk("data_addr", data_addr, m_addr);
                chk("data_wdata", data_wdata, m_wdata);
                chk("data_wstrb", 32'(data_wstrb), 32'(m_wstrb));
            end
        end
    end

    // ---------------- bus responder ----------------
    int cfg_await = 0;
    int cfg_dwait = 1;
    int rcnt, dcnt, dw;
    bit pend, req_seen;

    initial begin
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        rcnt = 0; dcnt = 0; dw = 1; pend = 1'b0; req_seen = 1'b0;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                pend = 1'b0; rcnt = 0;
            end else begin
                if (data_data_ok) pend = 1'b0;
                if (data_addr_ok) begin
                    pend = 1'b1; dcnt = 0; dw = cfg_dwait; rcnt = 0;
                end else if (req_seen) rcnt++;
                else rcnt = 0;
                if (pend) dcnt++;
            end
            #1;
            req_seen = data_req;
            data_addr_ok = data_req && (rcnt == cfg_await);
            data_data_ok = pend && (dcnt == dw);
        end
    end

    // ---------------- stimulus ----------------
    int s_stall, s_done, s_req;
    logic [31:0] s_ld, s_wdata, s_addr;
    logic [3:0]  s_wstrb;
    logic        s_adel, s_ades, s_wr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        mem_en = 1'b1; mem_wr = wr; mem_size = sz; mem_sext = sx;
        mem_addr = a; mem_wdata = wd; data_rdata = rd;
    endtask

    // Holds the current request until the pipeline is released (stall low).
    task automatic wait_done();
        bit fin = 1'b0;
        s_stall = 0; s_done = 0; s_req = 0; s_ld = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (i == 0) begin s_adel = adel; s_ades = ades; end
            if (stall) s_stall++;
            if (done) begin s_done++; s_ld = ld_data; end
            if (data_req) begin
                s_req++; s_wdata = data_wdata; s_wstrb = data_wstrb;
                s_addr = data_addr; s_wr = data_wr;
            end
            if (!stall) fin = 1'b1;
            else step();
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic run_acc(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int aw, input int dwt);
        cfg_await = aw; cfg_dwait = dwt;
        set_acc(wr, sz, sx, a, wd, rd);
        wait_done();
        step();
        mem_en = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        int f_done;
        resetn = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_sext = 1'b0;
        mem_addr = 0; mem_wdata = 0; flush = 1'b0; data_rdata = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        step();

        // Zero-wait word load.
        run_acc(0, 2'b10, 0, 32'h0000_1004, 0, 32'hDEAD_BEEF, 0, 1);
        chk("wl_ld", s_ld, 32'hDEAD_BEEF);
        chk("wl_stall", 32'(s_stall), 2);
        chk("wl_done", 32'(s_done), 1);

        // Byte loads from the top lane, signed then unsigned.
        run_acc(0, 2'b00, 1, 32'h0000_2003, 0, 32'h8012_3456, 0, 1);
        chk("lb_ld", s_ld, 32'hFFFF_FF80);
        run_acc(0, 2'b00, 0, 32'h0000_2003, 0, 32'h8012_3456, 0, 1);
        chk("lbu_ld", s_ld, 32'h0000_0080);
        run_acc(0, 2'b01, 1, 32'h0000_2002, 0, 32'hF00D_1234, 0, 1);
        chk("lh_ld", s_ld, 32'hFFFF_F00D);

        // Stores: half in upper lanes, byte in lane 1.
        run_acc(1, 2'b01, 0, 32'h0000_2002, 32'hFFFF_1234, 0, 0, 1);
        chk("sh_wdata", s_wdata, 32'h1234_1234);
        chk("sh_wstrb", 32'(s_wstrb), 32'hC);
        chk("sh_wr", 32'(s_wr), 1);
        run_acc(1, 2'b00, 0, 32'h0000_2001, 32'h1234_56AB, 0, 0, 1);
        chk("sb_wdata", s_wdata, 32'hABAB_ABAB);
        chk("sb_wstrb", 32'(s_wstrb), 32'h2);

        // Size 11 behaves as word.
        run_acc(0, 2'b11, 0, 32'h0000_7000, 0, 32'h0BAD_F00D, 0, 1);
        chk("sz3_ld", s_ld, 32'h0BAD_F00D);

        // addr_ok three cycles late, data_ok two cycles after acceptance.
        run_acc(0, 2'b10, 0, 32'h0000_1008, 0, 32'h1357_9BDF, 3, 2);
        chk("slow_req", 32'(s_req), 4);
        chk("slow_stall", 32'(s_stall), 6);
        chk("slow_done", 32'(s_done), 1);

        // Flush in WAIT; a back-to-back access waits out DISCARD.
        cfg_await = 0; cfg_dwait = 3; f_done = 0;
        set_acc(0, 2'b10, 0, 32'h0000_4000, 0, 32'h1111_2222);
        @(negedge clk); f_done += int'(done); step();
        @(negedge clk); f_done += int'(done); step();
        flush = 1'b1;
        @(negedge clk); f_done += int'(done);
        chk("fl_stall", 32'(stall), 0);
        step();
        flush = 1'b0; cfg_dwait = 1;
        set_acc(0, 2'b00, 1, 32'h0000_5001, 0, 32'h0000_A500);
        wait_done();
        step();
        mem_en = 1'b0;
        chk("fl_nodone", 32'(f_done), 0);
        chk("fl_bb_done", 32'(s_done), 1);
        chk("fl_bb_stall", 32'(s_stall), 4);
        chk("fl_bb_ld", s_ld, 32'hFFFF_FFA5);

        // Flush while the request is still unaccepted drops it.
        cfg_await = 5; cfg_dwait = 1;
        set_acc(0, 2'b10, 0, 32'h0000_4400, 0, 0);
        step(); step();
        flush = 1'b1; mem_en = 1'b0;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flreq_req", 32'(data_req), 0);
        step();

        // Misaligned word load and half store.
        run_acc(0, 2'b10, 0, 32'h0000_3002, 0, 32'h89AB_CDEF, 0, 1);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_adel", 32'(s_adel), 1);
        chk("mis_req", 32'(s_req), 0);
        chk("mis_done", 32'(s_done), 0);
`else
        chk("mis_adel", 32'(s_adel), 0);
        chk("mis_addr", s_addr, 32'h0000_3000);
        chk("mis_ld", s_ld, 32'h89AB_CDEF);
`endif
        run_acc(1, 2'b01, 0, 32'h0000_3001, 32'h0000_BEEF, 0, 0, 1);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_ades", 32'(s_ades), 1);
        chk("mis_sreq", 32'(s_req), 0);
`else
        chk("mis_ades", 32'(s_ades), 0);
        chk("mis_saddr", s_addr, 32'h0000_3000);
        chk("mis_sstrb", 32'(s_wstrb), 32'h3);
`endif

        // Reset mid-access, then recover.
        cfg_await = 0; cfg_dwait = 4;
        set_acc(0, 2'b10, 0, 32'h0000_6000, 0, 32'h5555_AAAA);
        step(); step();
        resetn = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_addr", data_addr, 0);
        step(); step();
        resetn = 1'b1;
        step(); step(); step();
        run_acc(0, 2'b10, 0, 32'h0000_6008, 0, 32'hCAFE_F00D, 0, 1);
        chk("post_rst_ld", s_ld, 32'hCAFE_F00D);
        chk("post_rst_stall", 32'(s_stall), 2);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
